// File: rtl/pll_lock_supervisor.sv
// Supervises the HDMI PLL: synchronises LOCK, pulses PLL reset with timeout/retry,
// and releases the HDMI domain reset only after lock has been stable.
module pll_lock_supervisor #(
   parameter int SYNC_STAGES      = 2,
   parameter int RST_PULSE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES   = 50000,
   parameter int STABLE_CYCLES    = 1024,
   parameter int MAX_RETRIES      = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   output logic       pll_rst,
   output logic       domain_rst_n,
   output logic       locked,
   output logic       fail,
   output logic [2:0] retry_count,
   output logic       lock_loss
);

   localparam int MAX_A   = (RST_PULSE_CYCLES > TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_MAX = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAIL
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       count;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;

   // pll_lock is asynchronous to clk, so nothing else may look at it directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      end
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   // One shared counter, cleared on every transition; outputs are set on the
   // transition edge so they change in the same cycle the state does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_RESET_PLL;
         count        <= '0;
         pll_rst      <= 1'b1;
         domain_rst_n <= 1'b0;
         locked       <= 1'b0;
         fail         <= 1'b0;
         retry_count  <= 3'd0;
         lock_loss    <= 1'b0;
      end else begin
         lock_loss <= 1'b0;
         count     <= count + CNT_W'(1);
         case (state)
            S_RESET_PLL: begin
               if (count == RST_LAST) begin
                  state   <= S_WAIT_LOCK;
                  count   <= '0;
                  pll_rst <= 1'b0;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state <= S_STABLE;
                  count <= '0;
               end else if (count == TIMEOUT_LAST) begin
                  count   <= '0;
                  pll_rst <= 1'b1;
                  if (retry_count == RETRY_LIMIT) begin
                     state <= S_FAIL;
                     fail  <= 1'b1;
                  end else begin
                     state       <= S_RESET_PLL;
                     retry_count <= retry_count + 3'd1;
                  end
               end
            end
            S_STABLE: begin
               if (!lock_s) begin
                  state <= S_WAIT_LOCK;
                  count <= '0;
               end else if (count == STABLE_LAST) begin
                  state        <= S_RUN;
                  count        <= '0;
                  locked       <= 1'b1;
                  domain_rst_n <= 1'b1;
                  retry_count  <= 3'd0;
               end
            end
            S_RUN: begin
               count <= '0;
               if (!lock_s) begin
                  state        <= S_RESET_PLL;
                  lock_loss    <= 1'b1;
                  locked       <= 1'b0;
                  domain_rst_n <= 1'b0;
                  pll_rst      <= 1'b1;
               end
            end
            S_FAIL: begin
               count        <= '0;
               pll_rst      <= 1'b1;
               fail         <= 1'b1;
               locked       <= 1'b0;
               domain_rst_n <= 1'b0;
            end
            default: begin
               state        <= S_RESET_PLL;
               count        <= '0;
               pll_rst      <= 1'b1;
               domain_rst_n <= 1'b0;
               locked       <= 1'b0;
            end
         endcase
      end
   end

endmodule
